// File: rtl/dds_wave_bank_ram_if.sv
// Avalon-MM slave bundle for dds_wave_bank_ram: CPU access to the shadow table and the CSR.
interface dds_wave_bank_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [ADDR_W:0]     address;
    logic                chipselect;
    logic                write;
    logic                read;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, chipselect, write, read, byteenable, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, read, byteenable, writedata,
        output readdata
    );
endinterface

// File: rtl/dds_wave_bank_ram.sv
// Ping-pong DDS waveform RAM with phase accumulator; bank swaps only on phase wrap or while stopped.
// Optional: define DDS_PHASE_OFFSET_EN to add a phase_offset input ahead of the table lookup.
module dds_wave_bank_ram #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int PHASE_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    dds_wave_bank_ram_if.slave    avs,
    input  logic                  run,
    input  logic [PHASE_W-1:0]    freq_word,
`ifdef DDS_PHASE_OFFSET_EN
    input  logic [PHASE_W-1:0]    phase_offset,
`endif
    output logic [DATA_W-1:0]     sample_out,
    output logic                  sample_valid,
    output logic                  active_bank
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef enum logic [1:0] {RD_NONE, RD_TABLE, RD_CSR} rd_sel_e;

    // Both banks live in one array; the MSB of the index is the bank number.
    word_t bank_mem [2*DEPTH];

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               active_bank_q, active_bank_d;
    logic               swap_pending_q, swap_pending_d;
    logic               run_d1_q;
    logic               sample_valid_q;
    word_t              sample_q;
    word_t              lut_rdata_q;
    word_t              tbl_rdata_q;
    word_t              csr_rdata_q;
    rd_sel_e            rd_sel_q, rd_sel_d;

    // ------------------------------------------------------------------
    // Avalon decode
    // ------------------------------------------------------------------
    logic              tbl_sel, csr_sel;
    logic              tbl_wr, tbl_rd, csr_wr, csr_rd;
    logic [ADDR_W:0]   shadow_idx;
    word_t             csr_word;

    assign tbl_sel    = avs.chipselect & ~avs.address[ADDR_W];
    assign csr_sel    = avs.chipselect & avs.address[ADDR_W] & (avs.address[ADDR_W-1:0] == '0);
    assign tbl_wr     = tbl_sel & avs.write;
    assign tbl_rd     = tbl_sel & avs.read;
    assign csr_wr     = csr_sel & avs.write;
    assign csr_rd     = csr_sel & avs.read;
    assign shadow_idx = {~active_bank_q, avs.address[ADDR_W-1:0]};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        csr_word    = '0;
        csr_word[0] = swap_pending_q;
        csr_word[1] = active_bank_q;
    end

    always_comb begin
        rd_sel_d = RD_NONE;
        if (tbl_rd) begin
            rd_sel_d = RD_TABLE;
        end else if (csr_rd) begin
            rd_sel_d = RD_CSR;
        end
    end

    always_comb begin
        avs.readdata = '0;
        case (rd_sel_q)
            RD_TABLE: avs.readdata = tbl_rdata_q;
            RD_CSR:   avs.readdata = csr_rdata_q;
            default:  avs.readdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Phase accumulator and swap control
    // ------------------------------------------------------------------
    logic [PHASE_W:0]   acc_sum;
    logic               wrap;
    logic               swap_fire;

    assign acc_sum   = {1'b0, acc_q} + {1'b0, freq_word};
    assign wrap      = run & acc_sum[PHASE_W];
    assign acc_d     = run ? acc_sum[PHASE_W-1:0] : acc_q;
    assign swap_fire = swap_pending_q & (wrap | ~run);

    always_comb begin
        swap_pending_d = swap_pending_q;
        if (swap_fire) begin
            swap_pending_d = 1'b0;
        end else if (csr_wr && avs.writedata[0]) begin
            swap_pending_d = 1'b1;
        end
    end

    assign active_bank_d = active_bank_q ^ swap_fire;

    // ------------------------------------------------------------------
    // Stage 0: lookup address, with the bank taken from the same cycle
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  lut_addr;
    logic [ADDR_W:0]    lut_idx;

`ifdef DDS_PHASE_OFFSET_EN
    logic [PHASE_W-1:0] lookup_phase;
    assign lookup_phase = acc_q + phase_offset;
    assign lut_addr     = lookup_phase[PHASE_W-1 -: ADDR_W];
`else
    assign lut_addr     = acc_q[PHASE_W-1 -: ADDR_W];
`endif

    assign lut_idx = {active_bank_q, lut_addr};

    // ------------------------------------------------------------------
    // Table storage: CPU read/write port on the shadow bank, DDS read port
    // ------------------------------------------------------------------
    // NOTE: the table array has no reset; a cleared RAM could not map to block memory and
    // software relies on partially written tables surviving a reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (tbl_wr && avs.byteenable[b]) begin
                bank_mem[shadow_idx][b*8 +: 8] <= avs.writedata[b*8 +: 8];
            end
        end
        tbl_rdata_q <= bank_mem[shadow_idx];
        lut_rdata_q <= bank_mem[lut_idx];
    end

    // ------------------------------------------------------------------
    // Control state and stage 2 output register
    // ------------------------------------------------------------------
    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q          <= '0;
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            run_d1_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_q       <= '0;
            rd_sel_q       <= RD_NONE;
            csr_rdata_q    <= '0;
        end else begin
            acc_q          <= acc_d;
            active_bank_q  <= active_bank_d;
            swap_pending_q <= swap_pending_d;
            run_d1_q       <= run;
            sample_valid_q <= run_d1_q;
            rd_sel_q       <= rd_sel_d;
            csr_rdata_q    <= csr_word;
            // Only samples fetched while running reach the output; otherwise it holds.
            if (run_d1_q) begin
                sample_q <= lut_rdata_q;
            end
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = sample_valid_q;
    assign active_bank  = active_bank_q;

endmodule
